gf163_affine_conv: RTL and testbench



---
 rtl/gf163_affine_conv.sv | 183 ++++++++++++++++++
 tb/tb_gf163_affine_conv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gf163_affine_conv.sv
// GF(2^163) projective-to-affine converter: registered Z feeds inversion_op, then x = X*Z^-1 by bit-serial multiply.
// Optional AFFINE_Y_EN adds a MULY pass producing y = Y*Z^-1; without it y_out is tied to zero.
module inversion_op (
  input  logic [162:0] i_a,
  output logic [162:0] o_inv
);
  localparam logic [162:0] RED = {155'b0, 8'hC9};

  function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
    logic [162:0] r;
    r = '0;
    for (int unsigned i = 0; i < 163; i++) begin
      r = {r[161:0], 1'b0} ^ (r[162] ? RED : '0) ^ (b[8'(162 - i)] ? a : '0);
    end
    return r;
  endfunction

  function automatic logic [162:0] gf_sqn(input logic [162:0] a, input int unsigned n);
    logic [162:0] r;
    r = a;
    for (int unsigned i = 0; i < n; i++) r = gf_mul(r, r);
    return r;
  endfunction

  // Itoh-Tsujii: b_k = a^(2^k-1), chain 1,2,4,5,10,20,40,80,81,162, then a^-1 = b_162^2
  function automatic logic [162:0] gf_inv(input logic [162:0] a);
    logic [162:0] b2, b4, b5, b10, b20, b40, b80, b81, b162;
    b2   = gf_mul(gf_sqn(a,    1),  a);
    b4   = gf_mul(gf_sqn(b2,   2),  b2);
    b5   = gf_mul(gf_sqn(b4,   1),  a);
    b10  = gf_mul(gf_sqn(b5,   5),  b5);
    b20  = gf_mul(gf_sqn(b10,  10), b10);
    b40  = gf_mul(gf_sqn(b20,  20), b20);
    b80  = gf_mul(gf_sqn(b40,  40), b40);
    b81  = gf_mul(gf_sqn(b80,  1),  a);
    b162 = gf_mul(gf_sqn(b81,  81), b81);
    return gf_sqn(b162, 1);
  endfunction

  assign o_inv = gf_inv(i_a);
endmodule

module gf163_affine_conv #(
  parameter int unsigned M = 163
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] x_in,
  input  logic [M-1:0] y_in,
  input  logic [M-1:0] z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] x_out,
  output logic [M-1:0] y_out,
  output logic         inf_out
);
  localparam logic [M-1:0] RED = {{(M-8){1'b0}}, 8'hC9};

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_MULX,
`ifdef AFFINE_Y_EN
    S_MULY,
`endif
    S_DONE
  } state_t;

  state_t       r_state;
  logic         r_in_ready, r_out_valid, r_inf;
  logic [M-1:0] r_x, r_z, r_zinv, r_acc, r_x_res;
  logic [7:0]   r_cnt;
  logic [M-1:0] w_inv, w_acc_next;
  logic         w_sel_bit;

  inversion_op u_inv (.i_a(r_z), .o_inv(w_inv));

`ifdef AFFINE_Y_EN
  logic [M-1:0] r_y, r_y_res;
  assign w_sel_bit = (r_state == S_MULY) ? r_y[r_cnt] : r_x[r_cnt];
  assign y_out     = r_y_res;
`else
  logic w_unused_y;
  assign w_unused_y = ^y_in;
  assign w_sel_bit  = r_x[r_cnt];
  assign y_out      = '0;
`endif

  always_comb begin
    w_acc_next = {r_acc[M-2:0], 1'b0} ^ (r_acc[M-1] ? RED : '0) ^ (w_sel_bit ? r_zinv : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_inf       <= 1'b0;
      r_x         <= '0;
      r_z         <= '0;
      r_zinv      <= '0;
      r_acc       <= '0;
      r_x_res     <= '0;
      r_cnt       <= '0;
`ifdef AFFINE_Y_EN
      r_y         <= '0;
      r_y_res     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x        <= x_in;
          r_z        <= z_in;
`ifdef AFFINE_Y_EN
          r_y        <= y_in;
`endif
          r_in_ready <= 1'b0;
          r_state    <= S_INV;
        end
        S_INV: begin
          r_zinv <= w_inv;
          if (r_z == '0) begin
            r_inf   <= 1'b1;
            r_x_res <= '0;
`ifdef AFFINE_Y_EN
            r_y_res <= '0;
`endif
            r_state <= S_DONE;
          end else begin
            r_acc   <= '0;
            r_cnt   <= 8'(M - 1);
            r_state <= S_MULX;
          end
        end
        S_MULX: begin
          r_acc <= w_acc_next;
          if (r_cnt == '0) begin
            r_x_res <= w_acc_next;
`ifdef AFFINE_Y_EN
            r_acc   <= '0;
            r_cnt   <= 8'(M - 1);
            r_state <= S_MULY;
`else
            r_state <= S_DONE;
`endif
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
`ifdef AFFINE_Y_EN
        S_MULY: begin
          r_acc <= w_acc_next;
          if (r_cnt == '0) begin
            r_y_res <= w_acc_next;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
`endif
        S_DONE: begin
          // first DONE edge raises out_valid; that extra edge is part of the fixed latency
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_inf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign x_out     = r_x_res;
  assign inf_out   = r_inf;
endmodule

// File: tb/tb_gf163_affine_conv.sv
// Self-checking bench for gf163_affine_conv: vector table, random operands against a field model, corner sequences.
module tb_gf163_affine_conv;
`ifdef AFFINE_Y_EN
  localparam bit YEN = 1'b1;
  localparam int LAT = 328;
`else
  localparam bit YEN = 1'b0;
  localparam int LAT = 165;
`endif

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, inf_out;
  logic [162:0] x_in, y_in, z_in, x_out, y_out;
  int           n_vec, n_err;

  gf163_affine_conv #(.M(163)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .inf_out(inf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // schoolbook carry-less product, then reduction by f = x^163+x^7+x^6+x^3+1
  function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
    logic [324:0] p, f, ae;
    p = '0; f = '0; ae = '0;
    ae[162:0] = a;
    f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
    for (int i = 0; i < 163; i++) if (b[i]) p = p ^ (ae << i);
    for (int i = 324; i >= 163; i--) if (p[i]) p = p ^ (f << (i - 163));
    return p[162:0];
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[162:0];
  endfunction

  task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 163'(in_ready), 163'(1));
    chk("rst_out_valid", 163'(out_valid), 163'(0));
    chk("rst_x_out", x_out, '0);
    chk("rst_inf_out", 163'(inf_out), 163'(0));
  endtask

  task automatic start(input logic [162:0] x, input logic [162:0] y, input logic [162:0] z);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 1000) begin @(negedge clk); w++; end
    chk("accept_ready", 163'(in_ready), 163'(1));
    x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (!out_valid && lat < 1000);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hs_out_valid", 163'(out_valid), 163'(0));
    chk("hs_in_ready", 163'(in_ready), 163'(1));
    chk("hs_inf_clear", 163'(inf_out), 163'(0));
  endtask

  typedef struct {
    logic [162:0] x, y, z, ex, ey;
    logic         einf;
    int           lat;
  } vec_t;

  function automatic vec_t mk(input logic [162:0] x, y, z, ex, ey, input logic einf, input int lat);
    vec_t v;
    v.x = x; v.y = y; v.z = z; v.ex = ex; v.ey = YEN ? ey : '0; v.einf = einf; v.lat = lat;
    return v;
  endfunction

  initial begin
    vec_t         vt[4];
    logic [162:0] ones, rx, ry, rz, held;
    int           lat;
    n_vec = 0; n_err = 0;
    ones = '1;
    vt[0] = mk(163'd1, 163'd1, 163'd1, 163'd1, 163'd1, 1'b0, LAT);
    vt[1] = mk(163'd4, 163'd6, 163'd2, 163'd2, 163'd3, 1'b0, LAT);
    vt[2] = mk(ones,   ones,   ones,   163'd1, 163'd1, 1'b0, LAT);
    vt[3] = mk(163'd5, 163'd7, 163'd0, 163'd0, 163'd0, 1'b1, 2);

    do_reset();

    for (int i = 0; i < 4; i++) begin
      start(vt[i].x, vt[i].y, vt[i].z);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 163'(lat), 163'(vt[i].lat));
      chk($sformatf("v%0d_x_out", i), x_out, vt[i].ex);
      chk($sformatf("v%0d_y_out", i), y_out, vt[i].ey);
      chk($sformatf("v%0d_inf_out", i), 163'(inf_out), 163'(vt[i].einf));
      release_out();
    end

    for (int i = 0; i < 8; i++) begin
      rx = rand163(); ry = rand163(); rz = rand163();
      if (rz == '0) rz = 163'd1;
      start(rx, ry, rz);
      wait_valid(lat);
      chk($sformatf("r%0d_latency", i), 163'(lat), 163'(LAT));
      chk($sformatf("r%0d_x_times_z", i), ref_mul(x_out, rz), rx);
      if (YEN) chk($sformatf("r%0d_y_times_z", i), ref_mul(y_out, rz), ry);
      else     chk($sformatf("r%0d_y_zero", i), y_out, '0);
      chk($sformatf("r%0d_inf", i), 163'(inf_out), 163'(0));
      release_out();
    end

    // backpressure: hold DONE for 20 cycles while a stray in_valid is offered
    start(163'd4, 163'd6, 163'd2);
    wait_valid(lat);
    held = x_out;
    chk("bp_x_out", held, 163'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = (i >= 5 && i < 15);
      x_in = 163'd9; z_in = 163'd3;
      chk($sformatf("bp_hold%0d", i), 163'({out_valid, in_ready, inf_out}), 163'(3'b100));
      chk($sformatf("bp_x%0d", i), x_out, held);
    end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    chk("bp_no_capture", 163'({in_ready, out_valid}), 163'(2'b10));

    // reset pulsed at cycle 80 of MULX discards the partial result
    start(163'd7, 163'd5, 163'd3);
    repeat (81) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 163'(in_ready), 163'(1));
    chk("arst_out_valid", 163'(out_valid), 163'(0));
    chk("arst_x_out", x_out, '0);
    chk("arst_y_out", y_out, '0);
    chk("arst_inf", 163'(inf_out), 163'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start(163'd4, 163'd6, 163'd2);
    wait_valid(lat);
    chk("post_rst_latency", 163'(lat), 163'(LAT));
    chk("post_rst_x_out", x_out, 163'd2);
    chk("post_rst_y_out", y_out, YEN ? 163'd3 : 163'd0);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
